// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_entry
//  Description : Debounced 10-key digit entry for a cooking timer. A raw key
//                sample is synchronised, debounced by a four-state FSM and
//                each accepted press is shifted into a three-digit BCD
//                register (mins / tens / ones) while loading is enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [9:0] keypad,
    input  logic       load_en,
    input  logic       clear_digits,
    output logic [3:0] mins,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam logic [7:0] c_DEB_LIMIT = 8'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2,
        S_RELEASE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_sync;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [7:0] w_cnt_inc;
    logic [3:0] r_code;
    logic [3:0] w_code_nxt;
    logic [3:0] w_dec;
    logic       w_none;
    logic       w_valid;
    logic       w_accept;
    logic [3:0] r_mins;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       r_key_valid;
    logic [3:0] r_key_code;

    // Single synchronising stage; every decision below looks only at r_sync.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_sync <= 10'd0;
        end else begin
            r_sync <= keypad;
        end
    end

    // Sample classification: none, exactly-one-hot (valid) or invalid.
    assign w_none    = (r_sync == 10'd0);
    assign w_valid   = !w_none && ((r_sync & (r_sync - 10'd1)) == 10'd0);
    assign w_cnt_inc = r_cnt + 8'd1;

    // Binary encode of the sampled key; only meaningful when w_valid is set.
    always_comb begin
        w_dec = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (r_sync[i]) begin
                w_dec = 4'(i);
            end
        end
    end

    // FSM state, debounce counter and captured key code registers.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_code  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // Next-state logic; the counter saturates at the limit because every
    // path that reaches the limit also leaves the counting state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_valid) begin
                    w_state_nxt = S_DEBOUNCE;
                    w_code_nxt  = w_dec;
                    w_cnt_nxt   = 8'd1;
                end else begin
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_DEBOUNCE: begin
                if (w_valid && (w_dec == r_code)) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_DEB_LIMIT) begin
                        w_state_nxt = S_HELD;
                        w_accept    = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_HELD: begin
                // Any nonzero pattern, even another key, keeps us held.
                if (w_none) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = 8'd1;
                end
            end
            S_RELEASE: begin
                if (w_none) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc >= c_DEB_LIMIT) begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_HELD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Accept handling: pulse, key code and the digit shift register.
    // A clear request wins over a shift landing on the same edge.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_mins      <= 4'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
        end else begin
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= r_code;
            end
            if (clear_digits) begin
                r_mins <= 4'd0;
                r_tens <= 4'd0;
                r_ones <= 4'd0;
            end else if (w_accept && load_en) begin
                r_mins <= r_tens;
                r_tens <= r_ones;
                r_ones <= r_code;
            end
        end
    end

    assign mins      = r_mins;
    assign tens      = r_tens;
    assign ones      = r_ones;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_entry
//  Description : Self-checking bench for keypad_entry. Table rows describe a
//                key press with its expected digits; accepted presses are
//                queued and matched against every key_valid pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry;

    localparam int DEB = 3;

    logic       clk;
    logic       clearn;
    logic [9:0] keypad;
    logic       load_en;
    logic       clear_digits;
    logic [3:0] mins;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       key_valid;
    logic [3:0] key_code;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulses = 0;
    int n_pushed = 0;
    logic [15:0] sb_q[$];

    typedef struct {
        logic [9:0] keys;
        int         hold;
        int         rel;
        bit         load;
        bit         clr;
        bit         acc;
        logic [3:0] code;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic [3:0] kc;
    } vec_t;

    vec_t tbl[11];

    keypad_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk          (clk),
        .clearn       (clearn),
        .keypad       (keypad),
        .load_en      (load_en),
        .clear_digits (clear_digits),
        .mins         (mins),
        .tens         (tens),
        .ones         (ones),
        .key_valid    (key_valid),
        .key_code     (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: each key_valid pulse must match the oldest queued accept.
    always @(negedge clk) begin
        if (clearn && key_valid) begin
            n_pulses++;
            if (sb_q.size() == 0) begin
                chk("unexpected_key_valid", {key_code, mins, tens, ones}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_accept", {key_code, mins, tens, ones}, sb_q.pop_front());
            end
        end
    end

    // Expects to be called right after a falling edge.
    task automatic apply(input vec_t v, input string name);
        load_en = v.load;
        keypad  = v.keys;
        if (v.acc) begin
            sb_q.push_back({v.code, v.m, v.t, v.o});
            n_pushed++;
        end
        for (int c = 1; c <= v.hold; c++) begin
            @(negedge clk);
            clear_digits = (v.clr && c == DEB);
            if (v.acc && c == DEB)     chk({name, "_kv_early"}, key_valid, 1'b0);
            if (v.acc && c == DEB + 1) chk({name, "_kv_latency"}, key_valid, 1'b1);
        end
        keypad       = 10'd0;
        clear_digits = 1'b0;
        repeat (v.rel) @(negedge clk);
        chk({name, "_digits"}, {mins, tens, ones}, {v.m, v.t, v.o});
        chk({name, "_key_code"}, key_code, v.kc);
    endtask

    // Drives nothing; checks the accept pulse arrives DEB+1 edges after the
    // current key pattern was applied, then keeps holding for hold cycles.
    task automatic timed_accept(input string name, input int hold);
        for (int c = 1; c <= hold; c++) begin
            @(negedge clk);
            if (c == DEB)     chk({name, "_kv_early"}, key_valid, 1'b0);
            if (c == DEB + 1) chk({name, "_kv_latency"}, key_valid, 1'b1);
        end
    endtask

    initial begin
        tbl[0]  = '{10'h004, 110, 6, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 4'd2, 4'd2};
        tbl[1]  = '{10'h020,  10, 6, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 4'd2, 4'd5, 4'd5};
        tbl[2]  = '{10'h200,  10, 6, 1'b1, 1'b0, 1'b1, 4'd9, 4'd2, 4'd5, 4'd9, 4'd9};
        tbl[3]  = '{10'h200,  10, 6, 1'b1, 1'b0, 1'b1, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
        tbl[4]  = '{10'h200,  10, 6, 1'b1, 1'b0, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
        tbl[5]  = '{10'h080,   2, 6, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 4'd9, 4'd9, 4'd9};
        tbl[6]  = '{10'h080,  10, 6, 1'b1, 1'b0, 1'b1, 4'd7, 4'd9, 4'd9, 4'd7, 4'd7};
        tbl[7]  = '{10'h010,  10, 6, 1'b0, 1'b0, 1'b1, 4'd4, 4'd9, 4'd9, 4'd7, 4'd4};
        tbl[8]  = '{10'h008,  10, 6, 1'b1, 1'b1, 1'b1, 4'd3, 4'd0, 4'd0, 4'd0, 4'd3};
        tbl[9]  = '{10'h001,  10, 6, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        tbl[10] = '{10'h100,  10, 6, 1'b1, 1'b0, 1'b1, 4'd8, 4'd0, 4'd0, 4'd8, 4'd8};

        clearn       = 1'b0;
        keypad       = 10'd0;
        load_en      = 1'b1;
        clear_digits = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {key_valid, key_code, mins, tens, ones}, 17'd0);
        clearn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i], $sformatf("row%0d", i));
        end

        // Two keys together never debounce; dropping one leaves a valid key.
        keypad = 10'h00A;
        repeat (20) @(negedge clk);
        chk("two_keys_no_accept", n_pulses, n_pushed);
        keypad = 10'h002;
        sb_q.push_back({4'd1, 4'd0, 4'd8, 4'd1});
        n_pushed++;
        timed_accept("two_keys", 10);
        // While held, an invalid pattern or a different key must not re-accept.
        keypad = 10'h022;
        repeat (10) @(negedge clk);
        keypad = 10'h004;
        repeat (10) @(negedge clk);
        keypad = 10'h000;
        repeat (8) @(negedge clk);
        chk("held_digits", {mins, tens, ones}, {4'd0, 4'd8, 4'd1});
        chk("held_key_code", key_code, 4'd1);

        // Asynchronous reset mid-debounce with the key kept down.
        load_en = 1'b1;
        keypad  = 10'h040;
        repeat (2) @(negedge clk);
        #2 clearn = 1'b0;
        #1 chk("async_reset_outputs", {key_valid, key_code, mins, tens, ones}, 17'd0);
        @(negedge clk);
        clearn = 1'b1;
        sb_q.push_back({4'd6, 4'd0, 4'd0, 4'd6});
        n_pushed++;
        timed_accept("after_reset", 30);
        keypad = 10'h000;
        repeat (8) @(negedge clk);
        chk("after_reset_digits", {mins, tens, ones}, {4'd0, 4'd0, 4'd6});
        chk("after_reset_key_code", key_code, 4'd6);

        chk("pulse_count", n_pulses, n_pushed);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 3, meaning: number of consecutive identical samples (range 2..255) required to accept a key press or a release.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 clearn  input  1  asynchronous, active-low reset for the whole block.
REQ-004 keypad  input  10  raw key lines; bit n high = digit key n pressed (n = 0..9).
REQ-005 load_en  input  1  high = accepted keys shift into the digit registers; low = digits frozen (cooking/paused).
REQ-006 clear_digits  input  1  synchronous request to zero all three digits.
REQ-007 mins  output  4  BCD minutes digit (most significant entered digit).
REQ-008 tens  output  4  BCD seconds-tens digit.
REQ-009 ones  output  4  BCD seconds-ones digit (last entered digit).
REQ-010 key_valid  output  1  one-cycle pulse per accepted key press.
REQ-011 key_code  output  4  binary value of the most recently accepted key; held until the next accept.

Function
REQ-012 keypad SHALL be registered once (sync stage) before any decision; FSM uses only the registered sample.
REQ-013 A sample is "valid" SHALL mean exactly one bit set; zero bits = "none"; two or more bits = "invalid" (treated as none for press detection).
REQ-014 FSM states SHALL be IDLE, DEBOUNCE, HELD, RELEASE.
REQ-015 IDLE: valid sample -> DEBOUNCE, capture decoded code, cnt=1; otherwise stay.
REQ-016 DEBOUNCE: sample equal to captured code -> cnt+1; on the edge cnt reaches DEBOUNCE_CYCLES -> HELD and accept; any other sample (none, invalid, different key) -> IDLE, cnt=0, no accept.
REQ-017 Accept SHALL, at one edge: key_valid=1 for one cycle, key_code=captured code, and if load_en=1: mins<=tens, tens<=ones, ones<=code.
REQ-018 Latency: with the key stable from edge 1 (first sync capture), accept SHALL occur at edge DEBOUNCE_CYCLES+1 (edge 4 at default).
REQ-019 HELD: none sample -> RELEASE, cnt=1; any nonzero sample (including a different key or invalid) -> stay HELD; no further accept while held.
REQ-020 RELEASE: none sample -> cnt+1, -> IDLE when cnt reaches DEBOUNCE_CYCLES; nonzero sample -> HELD.
REQ-021 Digits SHALL shift raw BCD without range check; tens values 6..9 are passed unchanged (downstream timer normalises).
REQ-022 Oldest digit (mins) SHALL be discarded on shift; no overflow flag.
REQ-023 clear_digits=1 SHALL zero mins/tens/ones at the next edge with priority over a simultaneous accept shift; key_valid/key_code of that accept still update.
REQ-024 load_en=0 at accept: key_valid and key_code SHALL still update; digits unchanged.
REQ-025 Counter width SHALL be 8 bits; never wraps (stops at DEBOUNCE_CYCLES).

Reset
REQ-026 clearn=0 SHALL immediately force: state IDLE, cnt=0, sync register=0, mins=tens=ones=0, key_code=0, key_valid=0.
REQ-027 Reset asserted mid-DEBOUNCE or mid-HELD SHALL lose the pending key; after release a held key is re-debounced from IDLE and accepted once.

Verification
REQ-028 load_en=1, press key 2 (bit 2) for 110 cycles, release; then 5, then 9 -> mins=2, tens=5, ones=9; exactly three key_valid pulses, first at edge 4 after press.
REQ-029 Continue with 9, 9 -> mins=9, tens=9, ones=9; key_code=9.
REQ-030 Glitch: key 7 for 2 cycles then none -> no key_valid, digits unchanged, FSM back to IDLE.
REQ-031 Two keys (bits 1 and 3) held 20 cycles -> no accept; release bit 3 -> key 1 accepted DEBOUNCE_CYCLES+1 edges later.
REQ-032 load_en=0, press key 4 -> key_valid pulse, key_code=4, digits unchanged; clear_digits pulse simultaneous with an accept -> digits=0,0,0.
REQ-033 clearn pulsed low while key 6 in DEBOUNCE with key still held -> all outputs 0 instantly; after release of clearn, key 6 accepted exactly once.
